// File: rtl/stopwatch_pkg.sv
// Shared constants and types for the lab3 stopwatch: BCD limits, default tick dividers
// and the packed MM:SS digit record.
package stopwatch_pkg;

  localparam logic [3:0] SEC_TENS_MAX = 4'd5;
  localparam logic [3:0] DIGIT_MAX    = 4'd9;
  localparam logic [3:0] MIN_TENS_MAX = 4'd9;

  // Dividers for the 100 MHz board clock; the display block uses the 666 Hz one for scanning.
  localparam int unsigned ONE_HZ_DIV_DEFAULT  = 100_000_000;
  localparam int unsigned TWO_HZ_DIV_DEFAULT  = 50_000_000;
  localparam int unsigned DISP_HZ_DIV_DEFAULT = 150_150;

  typedef struct packed {
    logic [3:0] min_tens;
    logic [3:0] min_units;
    logic [3:0] sec_tens;
    logic [3:0] sec_units;
  } bcd_time_t;

  // Increment one BCD digit, wrapping to zero once it has reached its limit.
  function automatic logic [3:0] bcd_inc(input logic [3:0] digit, input logic [3:0] max);
    return (digit == max) ? 4'd0 : digit + 4'd1;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running divider that emits a one-cycle strobe every DIV enabled cycles;
// the count is held at zero whenever en is low.
module tick_gen #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Gated by en so a stale terminal count cannot strobe in the cycle en drops.
  assign tick = en && (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q;
    if (!en || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch timekeeping core: MM:SS BCD counter with run/pause and minutes/seconds adjust,
// advanced by internal 1 Hz (run) and 2 Hz (adjust) strobes in a single clock domain.
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int unsigned ONE_HZ_DIV = ONE_HZ_DIV_DEFAULT,
  parameter int unsigned TWO_HZ_DIV = TWO_HZ_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pause,
  input  logic       adj,
  input  logic       sel,
  output logic [3:0] minutes_1,
  output logic [3:0] minutes_0,
  output logic [3:0] seconds_1,
  output logic [3:0] seconds_0,
  output logic       paused
);

  bcd_time_t time_q, time_d;
  logic      paused_q, paused_d;
  logic      one_hz_en, two_hz_en;
  logic      one_hz_tick, two_hz_tick;
  logic      sec_units_wrap, sec_wrap, min_units_wrap;

  // Uses the pre-toggle paused value, so a tick coinciding with a pause pulse still counts.
  assign one_hz_en = !adj && !paused_q;
  assign two_hz_en = adj;

  tick_gen #(
    .DIV(ONE_HZ_DIV)
  ) u_one_hz (
    .clk (clk),
    .rst (rst),
    .en  (one_hz_en),
    .tick(one_hz_tick)
  );

  tick_gen #(
    .DIV(TWO_HZ_DIV)
  ) u_two_hz (
    .clk (clk),
    .rst (rst),
    .en  (two_hz_en),
    .tick(two_hz_tick)
  );

  assign sec_units_wrap = (time_q.sec_units == DIGIT_MAX);
  assign sec_wrap       = sec_units_wrap && (time_q.sec_tens == SEC_TENS_MAX);
  assign min_units_wrap = (time_q.min_units == DIGIT_MAX);

  always_comb begin
    time_d   = time_q;
    paused_d = paused_q ^ pause;

    if (adj) begin
      if (two_hz_tick) begin
        if (sel) begin
          // Seconds field only: 59 -> 00 without carrying into minutes.
          time_d.sec_units = bcd_inc(time_q.sec_units, DIGIT_MAX);
          if (sec_units_wrap) begin
            time_d.sec_tens = bcd_inc(time_q.sec_tens, SEC_TENS_MAX);
          end
        end else begin
          time_d.min_units = bcd_inc(time_q.min_units, DIGIT_MAX);
          if (min_units_wrap) begin
            time_d.min_tens = bcd_inc(time_q.min_tens, MIN_TENS_MAX);
          end
        end
      end
    end else if (one_hz_tick) begin
      time_d.sec_units = bcd_inc(time_q.sec_units, DIGIT_MAX);
      if (sec_units_wrap) begin
        time_d.sec_tens = bcd_inc(time_q.sec_tens, SEC_TENS_MAX);
      end
      if (sec_wrap) begin
        time_d.min_units = bcd_inc(time_q.min_units, DIGIT_MAX);
        if (min_units_wrap) begin
          time_d.min_tens = bcd_inc(time_q.min_tens, MIN_TENS_MAX);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      time_q   <= '0;
      paused_q <= 1'b0;
    end else begin
      time_q   <= time_d;
      paused_q <= paused_d;
    end
  end

  assign minutes_1 = time_q.min_tens;
  assign minutes_0 = time_q.min_units;
  assign seconds_1 = time_q.sec_tens;
  assign seconds_0 = time_q.sec_units;
  assign paused    = paused_q;

endmodule

// File: doc/stopwatch_counter.md
Name: stopwatch_counter

Overview:
- Timekeeping core of the lab3 stopwatch, running on the 100 MHz board clock.
- Produces the four BCD digits (MM:SS) that the 7-segment display block consumes: minutes_1, minutes_0, seconds_1, seconds_0.
- Handles run/pause and adjust mode (adj/sel), so the display block only renders and blinks.
- Internal tick generators replace separate clock domains; all state sits in one clock domain.

Parameters:
- ONE_HZ_DIV, 100000000, clk cycles per normal-count tick (1 Hz).
- TWO_HZ_DIV, 50000000, clk cycles per adjust-mode tick (2 Hz).

Ports:
- clk  input  1  system clock, 100 MHz.
- rst  input  1  asynchronous, active-high reset.
- pause  input  1  single-cycle pulse, already debounced and synchronised upstream; toggles run/pause.
- adj  input  1  level; 1 = adjust mode.
- sel  input  1  level, adjust target; 0 = minutes, 1 = seconds.
- minutes_1  output  4  BCD tens of minutes, 0-9.
- minutes_0  output  4  BCD units of minutes, 0-9.
- seconds_1  output  4  BCD tens of seconds, 0-5.
- seconds_0  output  4  BCD units of seconds, 0-9.
- paused  output  1  1 while normal counting is halted by pause.

Behaviour:
- Reset (async, immediate, no clock edge needed): all digits 0, paused 0, both divider counters 0.
- Tick generation:
  - Tick = divider count equals DIV-1; it is a 1-cycle combinational strobe. The counter wraps to 0 on the same edge.
  - 1 Hz divider counts only when adj=0 and paused=0; otherwise it is held at 0.
  - 2 Hz divider counts only when adj=1; otherwise it is held at 0.
  - Consequence: the first tick comes DIV cycles after counting is enabled.
- Latency: digits update on the rising edge that ends the tick cycle. With ONE_HZ_DIV=4, seconds_0 becomes 1 on the 4th edge after rst deasserts.
- Normal mode (adj=0, paused=0), per 1 Hz tick:
  - seconds_0 increments; 9 -> 0 with carry into seconds_1.
  - seconds_1 5 -> 0 with carry into minutes_0.
  - minutes_0 9 -> 0 with carry into minutes_1.
  - minutes_1 9 -> 0. Full wrap: 99:59 -> 00:00.
- Adjust mode (adj=1), per 2 Hz tick:
  - sel=1: seconds field increments 00..59, 59 -> 00, no carry into minutes.
  - sel=0: minutes field increments 00..99, 99 -> 00; seconds unchanged.
  - Adjust works whether or not paused. The paused flag is not altered by adj.
- Pause:
  - Each pause pulse toggles paused.
  - A pulse and a 1 Hz tick in the same cycle: the tick is applied, because enable uses the pre-toggle paused value, and paused toggles on the same edge.
- sel change mid-adjust: takes effect on the next 2 Hz tick. The 2 Hz divider is not restarted.
- adj 1 -> 0: 2 Hz divider cleared; 1 Hz divider starts from 0.
- Digits are never outside legal BCD ranges. No illegal state is reachable, and illegal values are not checked.
- rst asserted mid-count: all state clears at once; counting resumes from 00:00 on the first edge after deassertion.

Decomposition:
- Shared package (stopwatch_pkg), constants:
  - SEC_TENS_MAX = 5
  - DIGIT_MAX = 9
  - MIN_TENS_MAX = 9
  - default divider counts for 1 Hz / 2 Hz / 666 Hz, which the display block also uses.
- One sub-module, tick_gen:
  - Parameter DIV; ports clk, rst, en, tick.
  - Counter clears when en=0.
  - Instantiated twice, for 1 Hz and 2 Hz.
- Digit increment/wrap logic stays in stopwatch_counter.

Test Plan (ONE_HZ_DIV=4, TWO_HZ_DIV=2):
- Reset, then run 4 cycles -> 00:01 on the 4th edge. After 240 cycles -> 01:00, paused=0.
- Run 24000 cycles -> 99:59 -> 00:00 wrap at exactly 24000 cycles; no illegal intermediate digit.
- At 00:03, pulse pause -> paused=1 and digits hold 00:03 for 40 cycles. Pulse again -> paused=0, 00:04 four cycles later. Also pulse pause in the same cycle as a tick -> that tick still counts.
- At 00:58, set adj=1, sel=1 -> seconds 59 after 2 cycles, 00 after 4 cycles; minutes stay 00. Repeat while paused=1 -> same result.
- At 98:10, set adj=1, sel=0 -> 99:10 then 00:10 at 2-cycle spacing. Drop adj -> next increment to 00:11 four cycles later.
- Assert rst asynchronously between edges at 12:34 -> all outputs 0 and paused 0 before the next clock edge.
